// File: rtl/sram_arb_pkg.sv
// Shared constants and types for controllers that front a single-port OpenRAM macro.
package sram_arb_pkg;

  // Macro geometry: 512 words of 32 data bits plus one spare bit, byte masked.
  localparam int SRAM_ADDR_WIDTH = 9;
  localparam int SRAM_DATA_WIDTH = 33;
  localparam int SRAM_NUM_WMASKS = 4;

  // Edges from handshake to dout0 capture (pins registered, then macro sample).
  localparam int READ_LATENCY = 2;

  // Requester index width large enough for the maximum of four requesters.
  localparam int MAX_ID_WIDTH = 2;

  // One in-flight access slot: whether it returns data, and to whom.
  typedef struct packed {
    logic                    is_read;
    logic [MAX_ID_WIDTH-1:0] id;
  } inflight_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at a registered
// pointer; the pointer moves past the winner on every grant and holds when idle.
module rr_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int IDX_WIDTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] valid,
  output logic [NUM_REQ-1:0] grant
);

  logic [IDX_WIDTH-1:0] ptr_q;
  logic [IDX_WIDTH-1:0] ptr_d;

  // Search requesters in order ptr, ptr+1, ... and grant the first valid one.
  always_comb begin : arb
    int cand;
    int win;
    grant = '0;
    win   = -1;
    cand  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end else begin
        cand = cand;
      end
      for (int j = 0; j < NUM_REQ; j++) begin
        if ((win < 0) && (cand == j) && valid[j]) begin
          win      = j;
          grant[j] = 1'b1;
        end else begin
          win = win;
        end
      end
    end
    if (win < 0) begin
      ptr_d = ptr_q;
    end else if (win == NUM_REQ - 1) begin
      ptr_d = '0;
    end else begin
      ptr_d = IDX_WIDTH'(win + 1);
    end
  end

  // Pointer register, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one 1RW SRAM macro port among NUM_REQ requesters with round-robin
// arbitration, registered macro pins and fixed-latency read return.
// Optional per-requester grant counters: define SRAM_ARB_STATS_EN.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int NUM_WMASKS = SRAM_NUM_WMASKS,
  parameter int ID_WIDTH   = MAX_ID_WIDTH
) (
  input  logic                             clk0,
  input  logic                             rst0_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  input  logic [NUM_REQ*NUM_WMASKS-1:0]    req_wmask,
  input  logic [NUM_REQ-1:0]               req_spare,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             sram_csb0,
  output logic                             sram_web0,
  output logic [NUM_WMASKS-1:0]            sram_wmask0,
  output logic                             sram_spare_wen0,
  output logic [ADDR_WIDTH-1:0]            sram_addr0,
  output logic [DATA_WIDTH-1:0]            sram_din0,
`ifdef SRAM_ARB_STATS_EN
  input  logic                             stats_clr,
  output logic [NUM_REQ*16-1:0]            grant_count,
`endif
  input  logic [DATA_WIDTH-1:0]            sram_dout0
);

  logic [NUM_REQ-1:0]    valid_s;
  logic [NUM_REQ-1:0]    grant_s;
  logic                  csb_q, csb_d, web_q, web_d, spare_q, spare_d;
  logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d, rdata_q, rdata_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  inflight_t             pipe_q [READ_LATENCY];
  inflight_t             pipe_d [READ_LATENCY];

  // Nobody is granted while reset is held.
  assign valid_s   = req_valid & {NUM_REQ{rst0_n}};
  assign req_ready = grant_s;

  rr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (ID_WIDTH)
  ) u_rr (
    .clk   (clk0),
    .rst_n (rst0_n),
    .valid (valid_s),
    .grant (grant_s)
  );

  // Select the winner's fields into the pin registers; idle cycles deselect
  // the macro and leave the other pins untouched; track the access in flight.
  always_comb begin
    csb_d       = 1'b1;
    web_d       = 1'b1;
    wmask_d     = wmask_q;
    spare_d     = spare_q;
    addr_d      = addr_q;
    din_d       = din_q;
    pipe_d[0]   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_s[i]) begin
        csb_d     = 1'b0;
        web_d     = ~req_we[i];
        addr_d    = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        din_d     = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        wmask_d   = req_we[i] ? req_wmask[i*NUM_WMASKS +: NUM_WMASKS] : '0;
        spare_d   = req_we[i] ? req_spare[i] : 1'b0;
        pipe_d[0] = '{is_read: ~req_we[i], id: MAX_ID_WIDTH'(i)};
      end else begin
        pipe_d[0] = pipe_d[0];
      end
    end
    for (int k = 1; k < READ_LATENCY; k++) begin
      pipe_d[k] = pipe_q[k-1];
    end
  end

  // Oldest in-flight slot: a read there has dout0 valid now; pulse its owner.
  always_comb begin
    rsp_valid_d = '0;
    rdata_d     = rdata_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_d[i] = pipe_q[READ_LATENCY-1].is_read &&
                       (pipe_q[READ_LATENCY-1].id == MAX_ID_WIDTH'(i));
    end
    if (pipe_q[READ_LATENCY-1].is_read) begin
      rdata_d = sram_dout0;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Pin, pipeline and response registers; reset drops every in-flight read.
  always_ff @(posedge clk0) begin
    if (!rst0_n) begin
      csb_q       <= 1'b1;
      web_q       <= 1'b1;
      wmask_q     <= '0;
      spare_q     <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      csb_q       <= csb_d;
      web_q       <= web_d;
      wmask_q     <= wmask_d;
      spare_q     <= spare_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      for (int k = 0; k < READ_LATENCY; k++) begin
        pipe_q[k] <= pipe_d[k];
      end
    end
  end

  assign sram_csb0       = csb_q;
  assign sram_web0       = web_q;
  assign sram_wmask0     = wmask_q;
  assign sram_spare_wen0 = spare_q;
  assign sram_addr0      = addr_q;
  assign sram_din0       = din_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rdata_q;

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];
  logic [15:0] cnt_d [NUM_REQ];

  // Saturating handshake counters; clear wins over a same-cycle grant.
  always_comb begin
    grant_count = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (stats_clr) begin
        cnt_d[i] = 16'h0000;
      end else if (grant_s[i] && (cnt_q[i] != 16'hFFFF)) begin
        cnt_d[i] = cnt_q[i] + 16'h0001;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
      grant_count[i*16 +: 16] = cnt_q[i];
    end
  end

  // Counter registers.
  always_ff @(posedge clk0) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rst0_n) begin
        cnt_q[i] <= 16'h0000;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`endif

endmodule
